// File: rtl/bus_pkg.sv
// bus_pkg: shared types and helpers for the serial-bus arbiter.
//   arb_state_t : arbiter FSM state encoding
//   sel_width() : bit count needed to index n items (never below 1)
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SELECT  = 2'd1,
    ST_CONNECT = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  // clog2 with a floor of 1 so a single master/slave still gets a real index bit
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req        [N-1:0] : request vector
//   last_grant [W-1:0] : index of the previously served requester
//   grant      [N-1:0] : one-hot winner (all zero when req is zero)
// The search starts at last_grant+1 and wraps modulo N.
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic [N-1:0] grant
);

  logic [W-1:0] idx;
  logic         found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = W'((int'(last_grant) + i) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_n.sv
// bus_arbiter_n: N-master to M-slave serial-bus arbiter with round-robin grant.
//   clk, reset (async, active-high)
//   m_request/m_address/m_data/m_valid/m_address_valid [NUM_MASTERS] : master side inputs
//   s_data_in/s_ready [NUM_SLAVES]                                   : slave side inputs
//   m_data_out, m_available/m_ready [NUM_MASTERS]                    : master side outputs
//   s_address/s_data/s_valid [NUM_SLAVES], err                       : slave side outputs / error pulse
// Optional feature: define ARB_TIMEOUT_EN to add a CONNECT watchdog of TIMEOUT_CYCLES.
//
// state   | meaning
// IDLE    | no grant; pick a winner when any request is up
// SELECT  | shift in SEL_W slave-select bits from the granted master
// CONNECT | granted master routed to the selected slave
// RELEASE | one-cycle gap; completion/error pulses visible, last_grant updated
module bus_arbiter_n
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_request,
  input  logic [NUM_MASTERS-1:0] m_address,
  input  logic [NUM_MASTERS-1:0] m_data,
  input  logic [NUM_MASTERS-1:0] m_valid,
  input  logic [NUM_MASTERS-1:0] m_address_valid,
  input  logic [NUM_SLAVES-1:0]  s_data_in,
  input  logic [NUM_SLAVES-1:0]  s_ready,
  output logic                   m_data_out,
  output logic [NUM_MASTERS-1:0] m_available,
  output logic [NUM_MASTERS-1:0] m_ready,
  output logic [NUM_SLAVES-1:0]  s_address,
  output logic [NUM_SLAVES-1:0]  s_data,
  output logic [NUM_SLAVES-1:0]  s_valid,
  output logic                   err
);

  localparam int SEL_W = sel_width(NUM_SLAVES);
  localparam int GNT_W = sel_width(NUM_MASTERS);
  localparam int CNT_W = 4;

  arb_state_t             state, state_nxt;
  logic [GNT_W-1:0]       gnt_idx, gnt_pick, last_grant;
  logic [NUM_MASTERS-1:0] gnt_oh;
  logic [SEL_W-1:0]       shift_q, shift_nxt;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   grant_load, shift_en, ready_nxt, err_nxt;
  logic                   ready_q, err_q, timeout_hit;

  rr_arbiter #(.N(NUM_MASTERS), .W(GNT_W)) u_rr (
    .req        (m_request),
    .last_grant (last_grant),
    .grant      (gnt_oh)
  );

  always_comb begin
    gnt_pick = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (gnt_oh[i]) gnt_pick = GNT_W'(i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant_load = 1'b0;
    shift_en   = 1'b0;
    ready_nxt  = 1'b0;
    err_nxt    = 1'b0;
    shift_nxt  = SEL_W'({shift_q, m_address[gnt_idx]});
    case (state)
      ST_IDLE: begin
        if (|m_request) begin
          grant_load = 1'b1;
          state_nxt  = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (!m_request[gnt_idx]) begin
          state_nxt = ST_RELEASE;
        end else if (m_address_valid[gnt_idx]) begin
          shift_en = 1'b1;
          if (bit_cnt == CNT_W'(SEL_W - 1)) begin
            if (int'(shift_nxt) >= NUM_SLAVES) begin
              err_nxt   = 1'b1;
              state_nxt = ST_RELEASE;
            end else begin
              state_nxt = ST_CONNECT;
            end
          end
        end
      end
      ST_CONNECT: begin
        // completion beats a simultaneous request drop or timeout
        if (s_ready[shift_q]) begin
          ready_nxt = 1'b1;
          state_nxt = ST_RELEASE;
        end else if (!m_request[gnt_idx]) begin
          state_nxt = ST_RELEASE;
        end else if (timeout_hit) begin
          err_nxt   = 1'b1;
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_idx    <= '0;
      last_grant <= GNT_W'(NUM_MASTERS - 1);
      shift_q    <= '0;
      bit_cnt    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ready_q <= ready_nxt;
      err_q   <= err_nxt;
      if (grant_load) begin
        gnt_idx <= gnt_pick;
        shift_q <= '0;
        bit_cnt <= '0;
      end else if (shift_en) begin
        shift_q <= shift_nxt;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (state == ST_RELEASE) last_grant <= gnt_idx;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // down-counter loaded on CONNECT entry; terminal count 0 marks the last allowed cycle
  logic [15:0] timer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      timer <= '0;
    else if (state == ST_SELECT && state_nxt == ST_CONNECT)
      timer <= 16'(TIMEOUT_CYCLES - 1);
    else if (state == ST_CONNECT && timer != '0)
      timer <= timer - 16'd1;
  end

  assign timeout_hit = (state == ST_CONNECT) && (timer == '0);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    m_available = '0;
    s_address   = '0;
    s_data      = '0;
    s_valid     = '0;
    m_data_out  = 1'b0;
    if (state == ST_SELECT || state == ST_CONNECT)
      m_available = NUM_MASTERS'(1) << gnt_idx;
    if (state == ST_CONNECT) begin
      s_address[shift_q] = m_address[gnt_idx];
      s_data[shift_q]    = m_data[gnt_idx];
      s_valid[shift_q]   = m_valid[gnt_idx];
      m_data_out         = s_data_in[shift_q];
    end
  end

  // pulses are registered, so they land in RELEASE while gnt_idx is still held
  assign m_ready = ready_q ? (NUM_MASTERS'(1) << gnt_idx) : '0;
  assign err     = err_q;

endmodule

// File: tb/tb_bus_arbiter_n.sv
module tb_bus_arbiter_n;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] m_request, m_address, m_data, m_valid, m_address_valid;
  logic [2:0] s_data_in, s_ready;
  logic       m_data_out;
  logic [1:0] m_available, m_ready;
  logic [2:0] s_address, s_data, s_valid;
  logic       err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_arbiter_n #(
    .NUM_MASTERS    (2),
    .NUM_SLAVES     (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .m_request       (m_request),
    .m_address       (m_address),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_address_valid (m_address_valid),
    .s_data_in       (s_data_in),
    .s_ready         (s_ready),
    .m_data_out      (m_data_out),
    .m_available     (m_available),
    .m_ready         (m_ready),
    .s_address       (s_address),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .err             (err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    m_address       = '0;
    m_data          = '0;
    m_valid         = '0;
    m_address_valid = '0;
    s_data_in       = '0;
    s_ready         = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    m_request = '0;
    idle_inputs();
    cyc();
    cyc();
    chk("rst_avail", m_available, 0);
    chk("rst_ready", m_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_route", {s_address, s_data, s_valid}, 0);
    chk("rst_dout", m_data_out, 0);

    // both request, master 0 wins first
    reset     = 1'b0;
    m_request = 2'b11;
    cyc();
    chk("grant_m0", m_available, 2'b01);

    // select bits 1,0 -> slave 2; nothing forwarded while selecting
    m_address = 2'b01; m_address_valid = 2'b01; m_valid = 2'b01; m_data = 2'b01; #1;
    chk("sel_no_fwd1", {s_address, s_data, s_valid}, 0);
    cyc();
    m_address = 2'b00; #1;
    chk("sel_no_fwd2", {s_address, s_data, s_valid}, 0);
    cyc();

    m_address_valid = '0; m_address = 2'b01; m_data = 2'b01; m_valid = 2'b01; s_data_in = 3'b100; #1;
    chk("route_addr", s_address, 3'b100);
    chk("route_data", s_data, 3'b100);
    chk("route_valid", s_valid, 3'b100);
    chk("route_dout", m_data_out, 1);
    chk("conn_avail", m_available, 2'b01);

    m_address = '0; m_data = '0; s_data_in = 3'b011; s_ready = 3'b001; #1;
    chk("dout_other", m_data_out, 0);
    chk("route_zero_valid", s_valid, 3'b100);
    cyc();
    chk("ignore_sready", {m_ready, m_available}, 4'b0001);

    s_ready = 3'b100; s_data_in = '0; m_valid = '0;
    cyc();
    s_ready = '0;
    chk("done_mready", m_ready, 2'b01);
    chk("release_avail", m_available, 0);
    chk("done_err", err, 0);
    cyc();
    chk("idle_mready", m_ready, 0);
    chk("idle_avail", m_available, 0);
    cyc();
    chk("grant_m1", m_available, 2'b10);

    // master 1 selects 3 -> bad select
    m_address = 2'b10; m_address_valid = 2'b10; #1;
    chk("bad_sel_nofwd", s_valid, 0);
    cyc();
    cyc();
    m_address = '0; m_address_valid = '0;
    chk("bad_err", err, 1);
    chk("bad_mready", m_ready, 0);
    chk("bad_avail", m_available, 0);
    chk("bad_svalid", s_valid, 0);
    cyc();
    chk("bad_err_pulse", err, 0);

    // round robin back to master 0; s_ready and request drop together
    cyc();
    chk("grant_rr_m0", m_available, 2'b01);
    m_address = '0; m_address_valid = 2'b01;
    cyc();
    cyc();
    m_address_valid = '0;
    m_valid = 2'b01; #1;
    chk("route_s0", s_valid, 3'b001);
    m_valid = '0; s_ready = 3'b001; m_request = 2'b10;
    cyc();
    s_ready = '0;
    chk("tie_mready", m_ready, 2'b01);
    chk("tie_err", err, 0);
    cyc();
    cyc();
    chk("grant_m1b", m_available, 2'b10);

    // master 1 to slave 1, then drop request
    m_address = 2'b00; m_address_valid = 2'b10;
    cyc();
    m_address = 2'b10;
    cyc();
    m_address = '0; m_address_valid = '0;
    m_valid = 2'b10; #1;
    chk("route_s1", s_valid, 3'b010);
    m_valid = '0; m_request = '0;
    cyc();
    chk("drop_release", {err, m_ready, m_available}, 0);
    cyc();

    // master 0 connects to slave 0 and never gets s_ready
    m_request = 2'b01;
    cyc();
    chk("grant_m0c", m_available, 2'b01);
    m_address_valid = 2'b01;
    cyc();
    cyc();
    m_address_valid = '0;
`ifdef ARB_TIMEOUT_EN
    for (int k = 2; k <= 16; k++) begin
      cyc();
      chk("to_hold", {err, m_available}, 3'b001);
    end
    cyc();
    m_request = '0;
    chk("to_err", err, 1);
    chk("to_release", m_available, 0);
    chk("to_mready", m_ready, 0);
    cyc();
    chk("to_err_clr", err, 0);
`else
    for (int k = 0; k < 40; k++) cyc();
    chk("no_to_avail", m_available, 2'b01);
    chk("no_to_err", err, 0);
    m_request = '0;
    cyc();
    chk("no_to_release", {err, m_ready, m_available}, 0);
    cyc();
`endif

    // master 1 to slave 2, then async reset mid-CONNECT
    m_request = 2'b11;
    cyc();
    chk("grant_m1c", m_available, 2'b10);
    m_address = 2'b10; m_address_valid = 2'b10;
    cyc();
    m_address = 2'b00;
    cyc();
    m_address_valid = '0;
    m_valid = 2'b10; m_data = 2'b10; s_data_in = 3'b100; #1;
    chk("pre_rst_valid", s_valid, 3'b100);
    chk("pre_rst_dout", m_data_out, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_avail", m_available, 0);
    chk("arst_route", {s_address, s_data, s_valid}, 0);
    chk("arst_dout", m_data_out, 0);
    chk("arst_flags", {m_ready, err}, 0);
    cyc();
    idle_inputs();
    reset = 1'b0;
    cyc();
    chk("post_rst_m0", m_available, 2'b01);
    chk("post_rst_flags", {m_ready, err}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
